gcd_controller: RTL and testbench

Control FSM for the GCD datapath; sits directly upstream of it, driving its load/select strobes and consuming its comparator flags. Accepts operand A, then operand B, through a valid/ready handshake while steering `data_in` into the datapath registers. Then runs the subtract-and-compare loop until the operands are equal, signalling completion with a one-cycle `done` pulse. The result sits in the datapath A register. A watchdog bounds the loop for degenerate inputs, such as a zero operand.

---
 rtl/gcd_controller.sv | 126 ++++++++++++
 tb/tb_gcd_controller.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/gcd_controller.sv
// Control FSM for the subtract-and-compare GCD datapath: loads A then B, loops to equality, pulses done.
// Define GCD_WATCHDOG_EN to bound the loop with an iteration counter and report aborts on err.
module gcd_controller #(
    parameter int MAX_ITER = 65535,
    parameter int CNT_W    = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic in_ready,
    input  logic lt,
    input  logic gt,
    input  logic eq,
    output logic ldA,
    output logic ldB,
    output logic sel_in,
    output logic sel1,
    output logic sel2,
    output logic busy,
    output logic done,
    output logic err
);

    typedef enum logic [1:0] {IDLE, LOADB, CMP, DONE} state_t;

    state_t state;
    logic   wd_hit;
    logic   err_flag;

`ifdef GCD_WATCHDOG_EN
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ITER);

    logic [CNT_W-1:0] cnt;

    // Equality wins over the watchdog, so only abort when the operands still differ.
    assign wd_hit = (cnt == MAX_CNT) && !eq;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            err_flag <= 1'b0;
        end else begin
            case (state)
                LOADB: if (in_valid) cnt <= '0;
                CMP: begin
                    if (!eq) begin
                        if (wd_hit)
                            err_flag <= 1'b1;
                        else if (gt || lt)
                            cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE:    err_flag <= 1'b0;
                default: ;
            endcase
        end
    end
`else
    logic [CNT_W-1:0] unused_max_iter;

    assign unused_max_iter = CNT_W'(MAX_ITER);
    assign wd_hit          = 1'b0;
    assign err_flag        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:  if (in_valid) state <= LOADB;
                LOADB: if (in_valid) state <= CMP;
                CMP:   if (eq || wd_hit) state <= DONE;
                DONE:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes are Mealy so a load lands on the same edge the flags are evaluated.
    always_comb begin
        in_ready = 1'b0;
        ldA      = 1'b0;
        ldB      = 1'b0;
        sel_in   = 1'b0;
        sel1     = 1'b0;
        sel2     = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    in_ready = 1'b1;
                    sel_in   = 1'b1;
                    ldA      = in_valid;
                end
                LOADB: begin
                    in_ready = 1'b1;
                    sel_in   = 1'b1;
                    busy     = 1'b1;
                    ldB      = in_valid;
                end
                CMP: begin
                    busy = 1'b1;
                    if (!eq && !wd_hit) begin
                        if (gt) begin
                            sel2 = 1'b1;
                            ldA  = 1'b1;
                        end else if (lt) begin
                            sel1 = 1'b1;
                            ldB  = 1'b1;
                        end
                    end
                end
                DONE: begin
                    done = 1'b1;
                    busy = 1'b1;
                    err  = err_flag;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_controller.sv
// Bench for gcd_controller: a behavioural GCD datapath closes the loop; a scoreboard checks each done.
module tb_gcd_controller;

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic in_ready;
    logic lt, gt, eq;
    logic ldA, ldB, sel_in, sel1, sel2, busy, done, err;

    logic [15:0] data_in;
    logic [15:0] ra = '0;
    logic [15:0] rb = '0;
    logic [15:0] m1, m2, bus;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int b_cyc = 0;
    int nsub = 0;
    int done_cnt = 0;

    typedef struct packed {
        logic [15:0] res;
        logic        err;
        logic [15:0] nsub;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    gcd_controller #(.MAX_ITER(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .lt(lt), .gt(gt), .eq(eq), .ldA(ldA), .ldB(ldB), .sel_in(sel_in),
        .sel1(sel1), .sel2(sel2), .busy(busy), .done(done), .err(err)
    );

    // Datapath model driven by the controller's strobes.
    always_comb begin
        m1  = sel1 ? rb : ra;
        m2  = sel2 ? rb : ra;
        bus = sel_in ? data_in : (m1 - m2);
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ldA) ra <= bus;
        if (ldB) rb <= bus;
    end

    assign lt = ra < rb;
    assign gt = ra > rb;
    assign eq = ra == rb;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic logic [8:0] outs();
        return {in_ready, ldA, ldB, sel_in, sel1, sel2, busy, done, err};
    endfunction

    // Monitor: tracks B acceptance and subtract strobes, pops the scoreboard on every done.
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready && ldB) begin
                b_cyc = cyc;
                nsub  = 0;
            end
            if ((ldA || ldB) && !sel_in) nsub++;
            if (done) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("result", ra, e.res);
                    check("err", err, e.err);
                    check("subtracts", nsub, e.nsub);
                    check("latency", cyc - b_cyc, e.nsub + 2);
                end
            end
        end
    end

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int gap,
                          input bit hold, input logic [15:0] res, input logic e_err,
                          input logic [15:0] e_nsub);
        bit got;
        exp_t e;
        in_valid = 1'b1;
        data_in  = a;
        @(negedge clk);
        check("accept_a", {in_ready, ldA, ldB}, 3'b110);
        @(posedge clk); #1;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            @(negedge clk);
            check("loadb_wait", {in_ready, ldB, busy}, 3'b101);
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        data_in  = b;
        e.res  = res;
        e.err  = e_err;
        e.nsub = e_nsub;
        sb.push_back(e);
        @(negedge clk);
        check("accept_b", {in_ready, ldA, ldB}, 3'b101);
        @(posedge clk); #1;
        if (hold) data_in = 16'd99;
        else in_valid = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (hold) check("hold_busy", {in_ready, sel_in}, 2'b00);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("done_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("back_idle", {in_ready, busy, done, err}, 4'b1000);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0, expected 1");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b1;
        data_in  = 16'd3;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", outs(), 9'd0);
        @(posedge clk); #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("first_ready", {in_ready, busy}, 2'b10);
        @(posedge clk); #1;

        run_op(16'd12, 16'd8,  0, 1'b0, 16'd4, 1'b0, 16'd2);
        run_op(16'd7,  16'd7,  0, 1'b0, 16'd7, 1'b0, 16'd0);
        run_op(16'd5,  16'd15, 3, 1'b0, 16'd5, 1'b0, 16'd2);
        run_op(16'd21, 16'd6,  0, 1'b0, 16'd3, 1'b0, 16'd4);
        run_op(16'd12, 16'd8,  0, 1'b1, 16'd4, 1'b0, 16'd2);

`ifdef GCD_WATCHDOG_EN
        run_op(16'd5, 16'd0, 0, 1'b0, 16'd5, 1'b1, 16'd8);
`endif

        // Abort a long run from inside CMP.
        in_valid = 1'b1;
        data_in  = 16'd1;
        @(posedge clk); #1;
        data_in  = 16'd65535;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("mid_reset_outputs", outs(), 9'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("mid_reset_no_done", {done, busy}, 2'b00);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_ready", {in_ready, busy}, 2'b10);
        @(posedge clk); #1;

        run_op(16'd9, 16'd6, 0, 1'b0, 16'd3, 1'b0, 16'd2);

        repeat (3) @(posedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
